// File: rtl/vproc_pkg.sv
// Shared types and constants for the vector processor front end.
//   state_t       : fetch FSM encoding (IDLE=0, FETCH=1, FULL=2, HALTED=3)
//   fetch_entry_t : one fetch buffer entry {pc, instr}
package vproc_pkg;

    localparam int unsigned INSTR_W       = 32;
    localparam int unsigned ADDR_W        = 32;
    localparam int unsigned ROM_WORDS_DEF = 64;
    localparam int unsigned ROM_BYTES     = 4 * ROM_WORDS_DEF;

    localparam logic [INSTR_W-1:0] NOP = INSTR_W'(0);

    typedef enum logic [1:0] {
        ST_IDLE   = 2'd0,
        ST_FETCH  = 2'd1,
        ST_FULL   = 2'd2,
        ST_HALTED = 2'd3
    } state_t;

    typedef struct packed {
        logic [ADDR_W-1:0]  pc;
        logic [INSTR_W-1:0] instr;
    } fetch_entry_t;

endpackage

// File: rtl/fetch_buf2.sv
// Two-entry FIFO of {pc, instr} with a registered head.
//   push/push_entry : write one entry (allowed when full only together with pop)
//   pop             : drop the head entry
//   flush           : empty the buffer, overrides push and pop
//   head/head_valid : registered copy of the oldest entry and its valid flag
//   count           : number of buffered entries (0..2)
module fetch_buf2
    import vproc_pkg::*;
(
    input  logic         clk,
    input  logic         rst_n,
    input  logic         push,
    input  fetch_entry_t push_entry,
    input  logic         pop,
    input  logic         flush,
    output fetch_entry_t head,
    output logic         head_valid,
    output logic [1:0]   count
);

    fetch_entry_t mem_q [2];
    fetch_entry_t mem_d [2];
    logic         wr_ptr_q, wr_ptr_d;
    logic         rd_ptr_q, rd_ptr_d;
    logic [1:0]   count_q, count_d;
    fetch_entry_t head_q, head_d;
    logic         head_valid_q, head_valid_d;

    // Pointer/count update; the head register is loaded from the post-update
    // storage so the new head is visible the cycle after it is pushed.
    always_comb begin
        mem_d    = mem_q;
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        count_d  = count_q;
        head_d   = head_q;
        if (flush) begin
            wr_ptr_d = 1'b0;
            rd_ptr_d = 1'b0;
            count_d  = 2'd0;
        end else begin
            if (push) begin
                mem_d[wr_ptr_q] = push_entry;
                wr_ptr_d        = ~wr_ptr_q;
            end
            if (pop) begin
                rd_ptr_d = ~rd_ptr_q;
            end
            count_d = count_q + 2'(push) - 2'(pop);
        end
        head_valid_d = (count_d != 2'd0);
        if (head_valid_d) begin
            head_d = mem_d[rd_ptr_d];
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            mem_q[0]     <= '0;
            mem_q[1]     <= '0;
            wr_ptr_q     <= 1'b0;
            rd_ptr_q     <= 1'b0;
            count_q      <= 2'd0;
            head_q       <= '0;
            head_valid_q <= 1'b0;
        end else begin
            mem_q        <= mem_d;
            wr_ptr_q     <= wr_ptr_d;
            rd_ptr_q     <= rd_ptr_d;
            count_q      <= count_d;
            head_q       <= head_d;
            head_valid_q <= head_valid_d;
        end
    end

    assign head       = head_q;
    assign head_valid = head_valid_q;
    assign count      = count_q;

endmodule

// File: rtl/fetch_sequencer.sv
// Instruction fetch controller for the combinational instruction ROM.
//   rom_address/rom_data            : ROM port (address = current pc)
//   instr/instr_pc/instr_valid/ready: decode handshake, head of fetch buffer
//   redirect_valid/redirect_target  : branch redirect, flushes the buffer
//   halt                            : suspend fetching while high
//   wrap_err/align_err              : sticky error flags
//   state                           : FSM state for debug
module fetch_sequencer
    import vproc_pkg::*;
#(
    parameter logic [31:0]  BASE_ADDRESS = 32'h0000_0000,
    parameter int unsigned  ROM_WORDS    = ROM_WORDS_DEF
) (
    input  logic        clk,
    input  logic        rst_n,
    output logic [31:0] rom_address,
    input  logic [31:0] rom_data,
    output logic [31:0] instr,
    output logic [31:0] instr_pc,
    output logic        instr_valid,
    input  logic        instr_ready,
    input  logic        redirect_valid,
    input  logic [31:0] redirect_target,
    input  logic        halt,
    output logic        wrap_err,
    output logic        align_err,
    output logic [1:0]  state
);

    localparam logic [ADDR_W-1:0] WIN_BYTES = ADDR_W'(4 * ROM_WORDS);
    localparam logic [ADDR_W-1:0] LAST_PC   = BASE_ADDRESS + WIN_BYTES - ADDR_W'(4);

    state_t            state_q, state_d;
    logic [ADDR_W-1:0] pc_q, pc_d;
    logic              wrap_err_q, wrap_err_d;
    logic              align_err_q, align_err_d;

    logic              push, pop, flush;
    fetch_entry_t      push_entry, head;
    logic              head_valid;
    logic [1:0]        count;
    logic [ADDR_W-1:0] target_al, target_off;

    fetch_buf2 u_buf (
        .clk        (clk),
        .rst_n      (rst_n),
        .push       (push),
        .push_entry (push_entry),
        .pop        (pop),
        .flush      (flush),
        .head       (head),
        .head_valid (head_valid),
        .count      (count)
    );

    assign pop        = head_valid & instr_ready;
    assign push_entry = '{pc: pc_q, instr: rom_data};
    assign target_al  = {redirect_target[31:2], 2'b00};
    assign target_off = target_al - BASE_ADDRESS;

    // Next state, pc and error flags; redirect wins over every state and halt.
    always_comb begin
        state_d     = state_q;
        pc_d        = pc_q;
        wrap_err_d  = wrap_err_q;
        align_err_d = align_err_q;
        push        = 1'b0;
        flush       = 1'b0;
        if (redirect_valid) begin
            flush   = 1'b1;
            state_d = ST_FETCH;
            if (target_off < WIN_BYTES) begin
                pc_d = target_al;
            end else begin
                pc_d       = BASE_ADDRESS;
                wrap_err_d = 1'b1;
            end
            if (redirect_target[1:0] != 2'b00) begin
                align_err_d = 1'b1;
            end
        end else begin
            case (state_q)
                ST_IDLE: state_d = ST_FETCH;
                ST_FETCH: begin
                    if (halt) begin
                        state_d = ST_HALTED;
                    end else if (count != 2'd2 || pop) begin
                        push = 1'b1;
                        if (pc_q == LAST_PC) begin
                            pc_d       = BASE_ADDRESS;
                            wrap_err_d = 1'b1;
                        end else begin
                            pc_d = pc_q + ADDR_W'(4);
                        end
                        if (count == 2'd1 && !pop) begin
                            state_d = ST_FULL;
                        end
                    end else begin
                        state_d = ST_FULL;
                    end
                end
                ST_FULL: begin
                    if (halt) begin
                        state_d = ST_HALTED;
                    end else if (pop) begin
                        state_d = ST_FETCH;
                    end
                end
                ST_HALTED: begin
                    if (!halt) begin
                        state_d = ST_FETCH;
                    end
                end
                default: state_d = ST_IDLE;
            endcase
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q     <= ST_IDLE;
            pc_q        <= BASE_ADDRESS;
            wrap_err_q  <= 1'b0;
            align_err_q <= 1'b0;
        end else begin
            state_q     <= state_d;
            pc_q        <= pc_d;
            wrap_err_q  <= wrap_err_d;
            align_err_q <= align_err_d;
        end
    end

    assign rom_address = pc_q;
    assign instr       = head.instr;
    assign instr_pc    = head.pc;
    assign instr_valid = head_valid;
    assign wrap_err    = wrap_err_q;
    assign align_err   = align_err_q;
    assign state       = state_q;

endmodule

// File: doc/fetch_sequencer.md
Name: fetch_sequencer

Overview:
Instruction fetch controller for the vector processor's combinational 64-word instruction ROM (word-addressed, 256-byte window at BASE_ADDRESS). It owns the program counter, drives the ROM address, and captures ROM data into a 2-entry buffer. It delivers instructions to decode over a valid/ready handshake. It also handles branch redirects (flush), halt, and misaligned/out-of-window targets.

Parameters:
BASE_ADDRESS, 32'h0000_0000, reset PC and base of the ROM window (must be 256-byte aligned)
ROM_WORDS, 64, words in the ROM window; wrap boundary = BASE_ADDRESS + 4*ROM_WORDS
BUF_DEPTH, 2, fetch buffer entries (fixed 2; 1-bit pointers plus count)

Ports:
clk  in  1  system clock, rising edge
rst_n  in  1  asynchronous active-low reset
rom_address  out  32  word-aligned address to ROM
rom_data  in  32  ROM output, combinational from rom_address
instr  out  32  instruction at head of buffer
instr_pc  out  32  address of instr
instr_valid  out  1  head entry valid
instr_ready  in  1  decode accepts head this cycle
redirect_valid  in  1  branch taken; one-cycle pulse
redirect_target  in  32  new PC
halt  in  1  level; suspend fetching while high
wrap_err  out  1  sticky; PC wrapped past end of window
align_err  out  1  sticky; redirect_target[1:0] != 0
state  out  2  FSM state, for debug

Behaviour:
- Reset (async, rst_n=0): pc=BASE_ADDRESS, buffer empty, instr_valid=0, instr=0, instr_pc=0, wrap_err=0, align_err=0, state=IDLE. rom_address=pc at all times, so it equals BASE_ADDRESS in reset.
- FSM states: IDLE=0, FETCH=1, FULL=2, HALTED=3.
  - IDLE -> FETCH on the first clock after reset release. No fetch happens in IDLE, so there is 1 cycle of startup latency.
  - FETCH: each cycle with space (count<2, or count==2 and a pop happens this cycle), push {pc, rom_data} and set pc += 4.
  - FETCH -> FULL when count reaches 2 with no pop. FULL -> FETCH on a pop.
  - Any state except IDLE -> HALTED when halt=1. HALTED -> FETCH when halt=0.
  - Buffered entries stay poppable in HALTED and FULL.
- Latency: the instruction at address A is visible on instr the cycle after pc==A is fetched. Steady state is 1 instruction/cycle with instr_ready held high.
- Handshake:
  - Pop occurs when instr_valid && instr_ready.
  - instr and instr_pc must stay stable while instr_valid && !instr_ready.
  - Push and pop in the same cycle are allowed at any count.
- Redirect (redirect_valid=1), highest priority:
  - Same cycle: no push. Next edge: buffer flushed (count=0), pc = {redirect_target[31:2], 2'b00}, state=FETCH. Redirect overrides halt for that edge. A concurrent pop is discarded by the flush.
  - align_err set if redirect_target[1:0] != 0.
  - Target outside the window: pc = BASE_ADDRESS and wrap_err set.
- Wrap: a fetch at pc = BASE_ADDRESS + 4*(ROM_WORDS-1) sets next pc = BASE_ADDRESS and sets wrap_err. Fetching continues.
- Reset mid-operation: asynchronous clear to the reset values above. Buffered instructions are lost.
- Arithmetic: pc is 32-bit unsigned; the increment is modulo the window. Sticky flags clear only on reset.

Decomposition:
- Shared package `vproc_pkg`:
  - FSM state encoding constants (ST_IDLE..ST_HALTED)
  - INSTR_W=32, ADDR_W=32
  - NOP encoding 32'h0
  - ROM window size constant
- One natural sub-module, `fetch_buf2`: 2-entry FIFO of {pc, instr} with push/pop/flush and count. The FSM and PC logic stay in the top module.

Test Plan:
- Reset release, instr_ready=1, ROM model loaded with word n = n → instr_valid rises on the 2nd edge after reset release; instr/instr_pc sequence 0/0x0, 1/0x4, 2/0x8, one per cycle.
- instr_ready=0 for 5 cycles after the first valid → state=FULL after 2 pushes, pc frozen at 0x8, instr held at 0 and instr_pc held at 0x0. On instr_ready=1, instrs resume 0, 1, 2 with no loss or duplicate.
- redirect_valid pulse with target 0x90 while count==2 → next cycle count=0 and instr_valid=0; the following cycle instr_pc=0x90 with instr=word 36. No stale 0x4/0x8 entries appear.
- halt=1 for 4 cycles with instr_ready=1 → state=HALTED and buffered entries drain. Then instr_valid=0 and pc is unchanged. After halt=0, fetch resumes at the held pc.
- Redirect to 0xF8, run 3 fetches → instr_pc 0xF8, 0xFC, 0x00, and wrap_err=1 after the 0xFC fetch.
- redirect_target 0x4A → align_err=1 and fetch resumes at 0x48. Assert rst_n=0 mid-stream → all outputs return immediately to their reset values.
